// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and helpers for the SPI word slave:
//                clock-polarity / clock-phase encodings and a ceil(log2)
//                helper used to size the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Clock polarity: level of spi_clk while the bus is idle.
    localparam bit c_CPOL_IDLE_LOW  = 1'b0;
    localparam bit c_CPOL_IDLE_HIGH = 1'b1;

    // Clock phase: which edge of a bit period samples data.
    localparam bit c_CPHA_LEADING   = 1'b0;
    localparam bit c_CPHA_TRAILING  = 1'b1;

    // ceil(log2(n)) for n >= 2; used for the bit counter width.
    function automatic int spi_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_sync
//  Description : Two-flop synchroniser plus one history flop for a single
//                asynchronous SPI pin, with rise/fall decode taken from the
//                last two stages.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_async  - asynchronous pin
//                o_level  - synchronised level (second stage)
//                o_rise   - one-cycle pulse on a synchronised 0->1
//                o_fall   - one-cycle pulse on a synchronised 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_hist <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    // The level is taken from the same stage that carries the new value of an
    // edge, so data and clock pins passed through identical instances stay
    // aligned to each other.
    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule : spi_edge_sync
`default_nettype wire

// File: rtl/spi_word_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_word_slave
//  Description : SPI slave exchanging WIDTH-bit words, fully oversampled in
//                the clk domain. Supports all four SPI modes, MSB- or
//                LSB-first, back-to-back words inside one chip-select window
//                and a one-word transmit holding register.
//  Ports       : clk, rst            - system clock, sync active-high reset
//                spi_clk/csn/mosi    - asynchronous SPI pins from the master
//                spi_miso/_oe        - slave data out and its drive enable
//                tx_data/valid/ready - write into the transmit holding reg
//                rx_data/rx_valid    - last complete received word + pulse
//                spi_sot/spi_eot     - chip-select fall / rise pulses
//                tx_underrun         - a word started with an empty holding reg
//                rx_abort            - window closed on a partial word
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_word_slave
    import spi_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             spi_csn,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             spi_sot,
    output logic             spi_eot,
    output logic             tx_underrun,
    output logic             rx_abort
);

    localparam int                 c_CNT_W    = spi_clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_csn_level,  w_csn_rise,  w_csn_fall;
    logic w_mosi_level, w_mosi_rise, w_mosi_fall;

    spi_edge_sync #(.RESET_VAL(CPOL)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_clk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_edge_sync #(.RESET_VAL(1'b1)) u_sync_csn (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_csn),
        .o_level (w_csn_level),
        .o_rise  (w_csn_rise),
        .o_fall  (w_csn_fall)
    );

    spi_edge_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_mosi),
        .o_level (w_mosi_level),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_level, w_mosi_rise, w_mosi_fall};

    // ------------------------------------------------------------------
    // Arming: after reset the synchroniser stages hold idle values, not the
    // real pins. If reset lands inside a transfer the pipeline would later
    // show a false chip-select fall. Nothing is decoded until the second
    // stage carries a genuine post-reset sample with chip select high, so a
    // new transfer needs a fresh chip-select fall.
    // ------------------------------------------------------------------
    logic [1:0] r_settle;
    logic       r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else if (r_settle != 2'd2) begin
            r_settle <= r_settle + 2'd1;
        end else if (w_csn_level) begin
            r_armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Edge qualification
    // ------------------------------------------------------------------
    logic w_lead, w_trail, w_window, w_sot, w_eot, w_sample, w_shift;

    assign w_lead   = (CPOL == c_CPOL_IDLE_LOW) ? w_sclk_rise : w_sclk_fall;
    assign w_trail  = (CPOL == c_CPOL_IDLE_LOW) ? w_sclk_fall : w_sclk_rise;
    assign w_window = r_armed & ~w_csn_level;
    assign w_sot    = r_armed & w_csn_fall;
    assign w_eot    = r_armed & w_csn_rise;
    // Start of transfer wins over a coincident clock edge.
    assign w_sample = w_window & ~w_sot & ((CPHA == c_CPHA_LEADING) ? w_lead : w_trail);
    assign w_shift  = w_window & ~w_sot & ((CPHA == c_CPHA_LEADING) ? w_trail : w_lead);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_rx_data;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic               r_rx_valid;
    logic               r_sot;
    logic               r_eot;
    logic               r_underrun;
    logic               r_abort;
    logic               r_urun_pend;

    logic               w_load;
    logic               w_wr;
    logic [WIDTH-1:0]   w_rx_next;
    logic [WIDTH-1:0]   w_tx_shifted;

    assign w_load = ((CPHA == c_CPHA_LEADING) & w_sot) | (w_shift & (r_bit_cnt == '0));
    assign w_wr   = tx_valid & ~r_hold_full;

    assign w_rx_next    = LSB_FIRST ? {w_mosi_level, r_rx_shift[WIDTH-1:1]}
                                    : {r_rx_shift[WIDTH-2:0], w_mosi_level};
    assign w_tx_shifted = LSB_FIRST ? {1'b0, r_tx_shift[WIDTH-1:1]}
                                    : {r_tx_shift[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rx_data   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_sot       <= 1'b0;
            r_eot       <= 1'b0;
            r_underrun  <= 1'b0;
            r_abort     <= 1'b0;
            r_urun_pend <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_sot      <= w_sot;
            r_eot      <= w_eot;
            r_abort    <= w_eot & (r_bit_cnt != '0);

            // Receive path
            if (w_sot || w_eot) begin
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_urun_pend <= 1'b0;
            end else if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == c_LAST_BIT) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
                // An empty load is reported once its zero word is really
                // being clocked out. In CPHA=0 the load at the final trailing
                // edge of a window is speculative; if chip select rises before
                // another sample edge it is dropped without an alarm.
                if (r_urun_pend) begin
                    r_underrun  <= 1'b1;
                    r_urun_pend <= 1'b0;
                end
            end

            // Transmit path (placed after the receive path so a load at
            // start-of-transfer can re-arm the pending underrun).
            if (w_load) begin
                r_tx_shift  <= r_hold_full ? r_hold : '0;
                r_hold_full <= 1'b0;
                if (!r_hold_full) begin
                    r_urun_pend <= 1'b1;
                end
            end else if (w_shift) begin
                r_tx_shift <= w_tx_shifted;
            end

            // A write in the same cycle as a load refills the register after
            // the load has seen it empty.
            if (w_wr) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_miso_oe = w_window;
    assign spi_miso    = w_window & (LSB_FIRST ? r_tx_shift[0] : r_tx_shift[WIDTH-1]);
    assign tx_ready    = ~r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign spi_sot     = r_sot;
    assign spi_eot     = r_eot;
    assign tx_underrun = r_underrun;
    assign rx_abort    = r_abort;

endmodule : spi_word_slave
`default_nettype wire
